// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: 2-FF input synchronizer, mid-bit sampling FSM,
// valid/ready byte handshake with framing-error and overrun pulses.
module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t                state;
    logic                  sync_q;
    logic                  rs;
    logic [TW-1:0]         tcnt;
    logic [BW-1:0]         bcnt;
    logic [DATA_BITS-1:0]  shreg;

    // Both stages reset high so an idle line never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
            rs     <= 1'b1;
        end else begin
            sync_q <= rx;
            rs     <= sync_q;
        end
    end

    // A delivery in the same cycle as an accept wins, so it is written after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rs) begin
                        state <= S_START;
                        tcnt  <= '0;
                    end
                end

                S_START: begin
                    if (b_tick) begin
                        if (tcnt == T_HALF) begin
                            tcnt <= '0;
                            if (rs) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_DATA;
                                bcnt  <= '0;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (b_tick) begin
                        if (tcnt == T_LAST) begin
                            tcnt  <= '0;
                            shreg <= {rs, shreg[DATA_BITS-1:1]};
                            if (bcnt == B_LAST) begin
                                state <= S_STOP;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                S_STOP: begin
                    if (b_tick) begin
                        if (tcnt == T_LAST) begin
                            tcnt <= '0;
                            if (rs) begin
                                state <= S_IDLE;
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BRK;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                // Hold off until the line returns high so a break cannot retrigger.
                S_BRK: begin
                    if (rs) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver with a valid/ready output handshake, framing-error detection and overrun reporting. It sits between the asynchronous `rx` pin and any byte consumer, such as a transmitter echo path, a command decoder or a FIFO. It shares the same `clk` domain and the same 16x baud-tick generator as the UART transmit path.

## Interface
- `DATA_BITS`, default 8: data bits per frame; LSB first; no parity.
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit period; must be even and ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `b_tick`  in  1  one-`clk`-wide pulse, OVERSAMPLE per bit period.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_BITS  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid` & `rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a new frame was dropped because the held byte was not yet accepted.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer.** `rx` passes through a 2-FF synchronizer whose FFs reset to 1. All decisions use the synchronized value `rs`.
- **Tick counter.** `tcnt` (width $clog2(OVERSAMPLE)) increments only on `b_tick` and clears on every state change.
- **IDLE.** `rs`=0 → START.
- **START.**
  - On the `b_tick` where `tcnt`=OVERSAMPLE/2−1 (mid start bit), sample `rs`.
  - `rs`=1 → IDLE (glitch rejected, nothing reported).
  - `rs`=0 → DATA with `bcnt`=0.
- **DATA.**
  - On the `b_tick` where `tcnt`=OVERSAMPLE−1, shift `rs` into the MSB of the shift register (right shift, so LSB first), then `bcnt`++.
  - After DATA_BITS samples → STOP.
- **STOP.** On the `b_tick` where `tcnt`=OVERSAMPLE−1, sample `rs`:
  - `rs`=1 → deliver the frame (see handshake), then → IDLE.
  - `rs`=0 → pulse `frame_err`, discard the byte, then → BRK.
- **BRK.** Wait for `rs`=1, then → IDLE. This prevents a held-low line or a break from retriggering.
- **Output handshake.**
  - Accept: `rx_valid` & `rx_ready` clears `rx_valid` on the next edge.
  - Delivery with `rx_valid`=0, or with an accept in the same cycle: load `rx_data` and set `rx_valid`=1. `overrun` stays 0.
  - Delivery with `rx_valid`=1 and no accept: keep the old `rx_data`, drop the new byte, pulse `overrun`.
  - `rx_data` changes only on a load.
- Frame error and overrun cannot occur on the same frame.
- `b_tick` is ignored in IDLE and BRK.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0; state IDLE; synchronizer FFs =1; counters 0.
- **Reset mid-frame:** immediate return to IDLE; the partial byte is lost and no flags are raised.
- **Sync latency:** 2 `clk` from a `rx` edge to `rs`.
- **Sample points,** counted in `b_tick` pulses after entering START:
  - start check: tick OVERSAMPLE/2;
  - data bit k (k = 0..DATA_BITS−1): tick OVERSAMPLE/2 + (k+1)·OVERSAMPLE;
  - stop bit: tick OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE.
  - For defaults these are ticks 8, 24…136, and 152.
- **Output latency:** `rx_valid`, `frame_err` and `overrun` are registered and assert on the `clk` edge after the stop-sample `b_tick`.
- **Pulse widths:** `frame_err` and `overrun` are exactly 1 `clk` wide.
- **`rx_busy`:** rises 1 `clk` after `rs` falls in IDLE; falls on the edge where the state returns to IDLE.
- **Minimum accept:** `rx_ready` may be tied high; `rx_valid` is then a 1-cycle pulse per frame.

## Test plan
Bench setup: 100 MHz `clk`, `b_tick` every 4 `clk`, line driven at 64 `clk`/bit.
1. **Normal frame.** Frame 0x55, `rx_ready`=1 → `rx_data`=0x55, `rx_valid` high 1 cycle, 1 `clk` after tick 152; `frame_err`=`overrun`=0.
2. **Glitch rejection.** `rx` low for 3 ticks (12 `clk`), then high → `rx_busy` pulses, no `rx_valid`/`frame_err`, state back to IDLE by tick 8.
3. **Framing error.** Frame 0xA3 with stop bit 0, line held low 5 more bit times → one `frame_err` pulse, no `rx_valid`, `rx_busy`=1 until line high. A following 0x3C frame is then received correctly.
4. **Overrun.** `rx_ready`=0; send 0x11 then 0x22 → `rx_data`=0x11 with `rx_valid`=1. `overrun` pulses once at the 0x22 stop sample, `rx_data` stays 0x11. Raising `rx_ready` for 1 cycle → `rx_valid`=0.
5. **Same-cycle accept and delivery.** Hold 0xF0 with `rx_valid`=1, and assert `rx_ready` exactly on the 0x0F stop-sample cycle → `rx_data`=0x0F, `rx_valid` stays 1, no `overrun`.
6. **Reset mid-frame.** Assert `rst` during data bit 4 of 0xC7 → all outputs 0 immediately. A clean 0x81 frame after release is received correctly.
